// File: rtl/tck7_udp_beacon_gen_if.sv
// rtl/tck7_udp_beacon_gen_if.sv - GMII transmit bundle driven by the UDP beacon generator
interface tck7_udp_beacon_gen_if;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic [7:0] gmii_txd;

  modport master (output gmii_tx_en, gmii_tx_er, gmii_txd);
  modport slave  (input  gmii_tx_en, gmii_tx_er, gmii_txd);
endinterface

// File: rtl/tck7_udp_beacon_gen.sv
// rtl/tck7_udp_beacon_gen.sv - periodic/triggered IPv4 UDP broadcast beacon built on the fly onto GMII
module tck7_udp_beacon_gen #(
  parameter int          PKT_DELAY_LIM = 125_000_000,
  parameter int          PAYLOAD_LEN   = 32,
  parameter int          IFG_CYCLES    = 12,
  parameter logic [47:0] SRC_MAC       = 48'h00_22_33_44_12_34,
  parameter logic [15:0] SRC_PORT      = 16'hBE9E,
  parameter logic [15:0] DST_PORT      = 16'h3039
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         trigger,
  input  logic [31:0]                  src_ip,
  output logic                         busy,
  output logic [31:0]                  pkt_cnt,
  tck7_udp_beacon_gen_if.master        gmii
);

  localparam logic [31:0] TIMER_LAST = 32'(PKT_DELAY_LIM - 1);
  localparam logic [15:0] PAY_LAST   = 16'(PAYLOAD_LEN - 1);
  localparam logic [15:0] IFG_LAST   = 16'(IFG_CYCLES - 1);
  localparam logic [15:0] IP_LEN     = 16'(28 + PAYLOAD_LEN);
  localparam logic [15:0] UDP_LEN    = 16'(8 + PAYLOAD_LEN);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_PAY, S_FCS, S_IFG} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] timer_q, timer_d;
  logic        pend_q, pend_d;
  logic [31:0] seq_q, seq_d;
  logic [31:0] ip_q, ip_d;
  logic [15:0] csum_q, csum_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  txd_q, txd_d;
  logic        busy_q, busy_d;

  logic        start, go;
  logic [7:0]  byte_w, hdr_b, pay_b, fcs_b;
  logic [19:0] sum_w;
  logic [16:0] fold1_w;
  logic [15:0] fold2_w;
  logic [31:0] fcs_w;

  // Reflected IEEE 802.3 CRC-32, one byte per call
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  // Nine fixed/latched header words; the checksum word itself counts as zero
  always_comb begin
    sum_w   = 20'h04500 + 20'(IP_LEN) + 20'(seq_q[15:0]) + 20'h04000 + 20'h04011
            + 20'(ip_q[31:16]) + 20'(ip_q[15:0]) + 20'h1FFFE;
    fold1_w = 17'(sum_w[15:0]) + 17'(sum_w[19:16]);
    fold2_w = fold1_w[15:0] + 16'(fold1_w[16]);
  end

  always_comb begin
    hdr_b = 8'h00;
    case (cnt_q[5:0])
      6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5: hdr_b = 8'hFF;
      6'd6:  hdr_b = SRC_MAC[47:40];
      6'd7:  hdr_b = SRC_MAC[39:32];
      6'd8:  hdr_b = SRC_MAC[31:24];
      6'd9:  hdr_b = SRC_MAC[23:16];
      6'd10: hdr_b = SRC_MAC[15:8];
      6'd11: hdr_b = SRC_MAC[7:0];
      6'd12: hdr_b = 8'h08;
      6'd14: hdr_b = 8'h45;
      6'd16: hdr_b = IP_LEN[15:8];
      6'd17: hdr_b = IP_LEN[7:0];
      6'd18: hdr_b = seq_q[15:8];
      6'd19: hdr_b = seq_q[7:0];
      6'd20: hdr_b = 8'h40;
      6'd22: hdr_b = 8'h40;
      6'd23: hdr_b = 8'h11;
      6'd24: hdr_b = csum_q[15:8];
      6'd25: hdr_b = csum_q[7:0];
      6'd26: hdr_b = ip_q[31:24];
      6'd27: hdr_b = ip_q[23:16];
      6'd28: hdr_b = ip_q[15:8];
      6'd29: hdr_b = ip_q[7:0];
      6'd30, 6'd31, 6'd32, 6'd33: hdr_b = 8'hFF;
      6'd34: hdr_b = SRC_PORT[15:8];
      6'd35: hdr_b = SRC_PORT[7:0];
      6'd36: hdr_b = DST_PORT[15:8];
      6'd37: hdr_b = DST_PORT[7:0];
      6'd38: hdr_b = UDP_LEN[15:8];
      6'd39: hdr_b = UDP_LEN[7:0];
      default: hdr_b = 8'h00;
    endcase
  end

  always_comb begin
    pay_b = cnt_q[7:0];
    case (cnt_q)
      16'd0:   pay_b = seq_q[31:24];
      16'd1:   pay_b = seq_q[23:16];
      16'd2:   pay_b = seq_q[15:8];
      16'd3:   pay_b = seq_q[7:0];
      default: pay_b = cnt_q[7:0];
    endcase
    fcs_w = ~crc_q;
    case (cnt_q[1:0])
      2'd0:    fcs_b = fcs_w[7:0];
      2'd1:    fcs_b = fcs_w[15:8];
      2'd2:    fcs_b = fcs_w[23:16];
      default: fcs_b = fcs_w[31:24];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    pend_d    = pend_q;
    seq_d     = seq_q;
    ip_d      = ip_q;
    csum_d    = csum_q;
    crc_d     = crc_q;
    pkt_cnt_d = pkt_cnt_q;
    tx_en_d   = 1'b0;
    byte_w    = 8'h00;
    go        = 1'b0;
    timer_d   = (!enable || timer_q == TIMER_LAST) ? 32'd0 : timer_q + 32'd1;
    start     = enable & ((timer_q == TIMER_LAST) | trigger);

    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        go    = start | pend_q;
      end
      S_PRE: begin
        tx_en_d = 1'b1;
        byte_w  = (cnt_q == 16'd7) ? 8'hD5 : 8'h55;
        csum_d  = ~fold2_w;
        crc_d   = 32'hFFFF_FFFF;
        if (cnt_q == 16'd7) begin
          state_d = S_HDR;
          cnt_d   = 16'd0;
        end
      end
      S_HDR: begin
        tx_en_d = 1'b1;
        byte_w  = hdr_b;
        crc_d   = crc_byte(crc_q, hdr_b);
        if (cnt_q == 16'd41) begin
          state_d = S_PAY;
          cnt_d   = 16'd0;
        end
      end
      S_PAY: begin
        tx_en_d = 1'b1;
        byte_w  = pay_b;
        crc_d   = crc_byte(crc_q, pay_b);
        if (cnt_q == PAY_LAST) begin
          state_d = S_FCS;
          cnt_d   = 16'd0;
        end
      end
      S_FCS: begin
        tx_en_d = 1'b1;
        byte_w  = fcs_b;
        if (cnt_q == 16'd3) begin
          state_d   = S_IFG;
          cnt_d     = 16'd0;
          pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
      end
      S_IFG: begin
        if (cnt_q == IFG_LAST) begin
          if (pend_q || start) go = 1'b1;
          else state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A start that cannot be served right now is remembered once; extra ones are lost
    if (start && !go) pend_d = 1'b1;
    if (go) begin
      state_d = S_PRE;
      cnt_d   = 16'd0;
      pend_d  = 1'b0;
      seq_d   = pkt_cnt_q;
      ip_d    = src_ip;
    end
    busy_d = (state_d != S_IDLE);
    txd_d  = tx_en_d ? byte_w : 8'h00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      timer_q   <= '0;
      pend_q    <= 1'b0;
      seq_q     <= '0;
      ip_q      <= '0;
      csum_q    <= '0;
      crc_q     <= '1;
      pkt_cnt_q <= '0;
      tx_en_q   <= 1'b0;
      txd_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      pend_q    <= pend_d;
      seq_q     <= seq_d;
      ip_q      <= ip_d;
      csum_q    <= csum_d;
      crc_q     <= crc_d;
      pkt_cnt_q <= pkt_cnt_d;
      tx_en_q   <= tx_en_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
    end
  end

  assign gmii.gmii_tx_en = tx_en_q;
  assign gmii.gmii_tx_er = 1'b0;
  assign gmii.gmii_txd   = txd_q;
  assign busy            = busy_q;
  assign pkt_cnt         = pkt_cnt_q;

endmodule

// File: tb/tb_tck7_udp_beacon_gen.sv
// tb/tb_tck7_udp_beacon_gen.sv - scoreboard bench: triggered unit (N=18) and periodic unit (N=32, 300-cycle timer)
module tb_tck7_udp_beacon_gen;

  typedef struct packed {
    logic [1023:0] d;
    logic [31:0]   len;
    logic [31:0]   t0;
  } frame_t;

  localparam logic [47:0] MAC = 48'h00_22_33_44_12_34;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, en_b, trig_a, trig_b;
  logic [31:0] ip_a, ip_b;
  logic        busy_a, busy_b;
  logic [31:0] pkt_cnt_a, pkt_cnt_b;

  tck7_udp_beacon_gen_if if_a ();
  tck7_udp_beacon_gen_if if_b ();

  tck7_udp_beacon_gen #(.PKT_DELAY_LIM(50000), .PAYLOAD_LEN(18), .IFG_CYCLES(12)) dut_a (
    .clk(clk), .reset(rst), .enable(en_a), .trigger(trig_a), .src_ip(ip_a),
    .busy(busy_a), .pkt_cnt(pkt_cnt_a), .gmii(if_a));

  tck7_udp_beacon_gen #(.PKT_DELAY_LIM(300), .PAYLOAD_LEN(32), .IFG_CYCLES(12)) dut_b (
    .clk(clk), .reset(rst), .enable(en_b), .trigger(trig_b), .src_ip(ip_b),
    .busy(busy_b), .pkt_cnt(pkt_cnt_b), .gmii(if_b));

  always #5 clk = ~clk;

  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  int     spurious = 0;
  int     idle_bad = 0;
  logic   trunc [2];
  logic   inf [2];
  frame_t cur [2];
  frame_t last [2];
  frame_t exp_a [$];
  frame_t exp_b [$];
  logic       tx_en_w [2];
  logic [7:0] txd_w [2];

  assign tx_en_w[0] = if_a.gmii_tx_en;
  assign tx_en_w[1] = if_b.gmii_tx_en;
  assign txd_w[0]   = if_a.gmii_txd;
  assign txd_w[1]   = if_b.gmii_txd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_frame(string tag, frame_t g, frame_t e);
    int bad;
    bad = 0;
    for (int i = 127; i >= 0; i--) if (g.d[8*i +: 8] !== e.d[8*i +: 8]) bad = i;
    checks++;
    assert (g.d === e.d) else begin
      errors++;
      $error("FAIL %s byte=%0d observed=%h expected=%h", tag, bad, g.d[8*bad +: 8], e.d[8*bad +: 8]);
    end
  endtask

  function automatic logic [31:0] crc_upd(logic [31:0] c, logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] residue(frame_t f);
    logic [31:0] c, r;
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < int'(f.len); i++) c = crc_upd(c, f.d[8*i +: 8]);
    for (int b = 0; b < 32; b++) r[b] = c[31-b];
    return r;
  endfunction

  function automatic logic [7:0] fbyte(frame_t f, int i);
    return f.d[8*i +: 8];
  endfunction

  function automatic frame_t build(int n, logic [31:0] seq, logic [31:0] ip, int t0);
    frame_t      f;
    logic [7:0]  fb [0:127];
    logic [15:0] w [0:9];
    logic [47:0] mac;
    logic [31:0] c;
    int          s;
    mac = MAC;
    for (int i = 0; i < 128; i++) fb[i] = 8'h00;
    for (int i = 0; i < 7; i++) fb[i] = 8'h55;
    fb[7] = 8'hD5;
    for (int i = 0; i < 6; i++) begin
      fb[8+i]  = 8'hFF;
      fb[14+i] = mac[8*(5-i) +: 8];
    end
    fb[20] = 8'h08; fb[21] = 8'h00;
    w[0] = 16'h4500; w[1] = 16'(28 + n); w[2] = seq[15:0]; w[3] = 16'h4000; w[4] = 16'h4011;
    w[5] = 16'h0000; w[6] = ip[31:16]; w[7] = ip[15:0]; w[8] = 16'hFFFF; w[9] = 16'hFFFF;
    s = 0;
    for (int j = 0; j < 10; j++) s += int'(w[j]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >>> 16);
    w[5] = ~16'(s);
    for (int j = 0; j < 10; j++) begin
      fb[22+2*j] = w[j][15:8];
      fb[23+2*j] = w[j][7:0];
    end
    fb[42] = 8'hBE; fb[43] = 8'h9E; fb[44] = 8'h30; fb[45] = 8'h39;
    fb[46] = 8'(((8 + n) >> 8) & 8'hFF); fb[47] = 8'((8 + n) & 8'hFF);
    for (int k = 0; k < n; k++) fb[50+k] = (k < 4) ? seq[8*(3-k) +: 8] : 8'(k);
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < 50 + n; i++) c = crc_upd(c, fb[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) fb[50+n+i] = c[8*i +: 8];
    f = '0;
    for (int i = 0; i < 128; i++) f.d[8*i +: 8] = fb[i];
    f.len = 32'(54 + n);
    f.t0  = 32'(t0);
    return f;
  endfunction

  task automatic got_frame(int d, frame_t g);
    frame_t e;
    if (trunc[d]) begin
      trunc[d] = 1'b0;
      chk("trunc_len", g.len, 32'd41);
      return;
    end
    if ((d == 0 && exp_a.size() == 0) || (d == 1 && exp_b.size() == 0)) begin
      spurious++;
      return;
    end
    if (d == 0) e = exp_a.pop_front();
    else        e = exp_b.pop_front();
    chk(d == 0 ? "a_len" : "b_len", g.len, e.len);
    chk(d == 0 ? "a_start" : "b_start", g.t0, e.t0);
    chk_frame(d == 0 ? "a_bytes" : "b_bytes", g, e);
    chk(d == 0 ? "a_residue" : "b_residue", residue(g), 32'hC704DD7B);
    last[d] = g;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (tx_en_w[d]) begin
        if (!inf[d]) begin
          cur[d]    = '0;
          cur[d].t0 = 32'(cyc);
          inf[d]    = 1'b1;
        end
        if (cur[d].len < 128) cur[d].d[8*cur[d].len +: 8] = txd_w[d];
        cur[d].len = cur[d].len + 32'd1;
      end else begin
        if (txd_w[d] !== 8'h00) idle_bad++;
        if (inf[d]) begin
          inf[d] = 1'b0;
          got_frame(d, cur[d]);
        end
      end
    end
  end

  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int r, t, t0, lowcnt;
    trunc[0] = 1'b0; trunc[1] = 1'b0;
    inf[0] = 1'b0; inf[1] = 1'b0;
    rst = 1'b1; en_a = 1'b1; en_b = 1'b1; trig_a = 1'b0; trig_b = 1'b0;
    ip_a = 32'hC0A8_01EA; ip_b = $urandom;
    repeat (3) @(negedge clk);
    chk("rst_tx_en_a", if_a.gmii_tx_en, 0);
    chk("rst_txd_a", if_a.gmii_txd, 0);
    chk("rst_tx_er_a", if_a.gmii_tx_er, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_pkt_cnt_a", pkt_cnt_a, 0);
    chk("rst_tx_en_b", if_b.gmii_tx_en, 0);
    rst = 1'b0;
    r = cyc;

    // periodic unit: 20 frames, then a 21st during which enable drops
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) begin
        wait_cyc(r + 151 + 300*k);
        chk("b_pkt_cnt", pkt_cnt_b, k);
      end
      ip_b = $urandom;
      exp_b.push_back(build(32, k, ip_b, r + 301 + 300*k));
    end
    wait_cyc(r + 6301 + 20);
    en_b = 1'b0;
    wait_cyc(r + 6301 + 700);
    chk("b_pkt_cnt_after_disable", pkt_cnt_b, 21);
    chk("b_timer_held", dut_b.timer_q, 0);
    chk("b_busy_idle", busy_b, 0);
    chk("b_tx_er", if_b.gmii_tx_er, 0);

    // minimum frame on the triggered unit
    ip_a = 32'hC0A8_01EA;
    @(negedge clk);
    trig_a = 1'b1; t = cyc;
    exp_a.push_back(build(18, 0, ip_a, t + 2));
    chk("a_busy_before", busy_a, 0);
    @(negedge clk);
    trig_a = 1'b0;
    chk("a_busy_rise", busy_a, 1);
    wait_cyc(t + 120);
    chk("a_iplen_hi", fbyte(last[0], 24), 8'h00);
    chk("a_iplen_lo", fbyte(last[0], 25), 8'h2E);
    chk("a_csum_hi", fbyte(last[0], 32), 8'h78);
    chk("a_csum_lo", fbyte(last[0], 33), 8'h2D);
    chk("a_udplen", {fbyte(last[0], 46), fbyte(last[0], 47)}, 16'h001A);
    chk("a_seq0", {fbyte(last[0], 50), fbyte(last[0], 51), fbyte(last[0], 52), fbyte(last[0], 53)}, 0);
    chk("a_pkt_cnt1", pkt_cnt_a, 1);

    // trigger during a frame (pending), then during its IFG (dropped)
    @(negedge clk);
    trig_a = 1'b1; t = cyc; t0 = t + 2;
    exp_a.push_back(build(18, 1, ip_a, t0));
    @(negedge clk);
    trig_a = 1'b0;
    lowcnt = 0;
    while (cyc < t0 + 84) begin
      @(negedge clk);
      trig_a = (cyc == t0 + 30) || (cyc == t0 + 75);
      if (cyc == t0 + 20) ip_a = $urandom;
      if (cyc == t0 + 30) exp_a.push_back(build(18, 2, ip_a, t0 + 84));
      if (cyc >= t0 + 72 && !busy_a) lowcnt++;
    end
    trig_a = 1'b0;
    chk("a_busy_gap_low", lowcnt, 0);
    wait_cyc(t0 + 84 + 72 + 60);
    chk("a_pkt_cnt3", pkt_cnt_a, 3);
    chk("a_busy_after_pend", busy_a, 0);

    // asynchronous reset while byte 40 is on the wire
    @(negedge clk);
    ip_a = $urandom; trig_a = 1'b1; t0 = cyc + 2; trunc[0] = 1'b1;
    @(negedge clk);
    trig_a = 1'b0;
    wait_cyc(t0 + 40);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx_en", if_a.gmii_tx_en, 0);
    chk("async_rst_txd", if_a.gmii_txd, 0);
    chk("async_rst_pkt_cnt", pkt_cnt_a, 0);
    chk("async_rst_busy", busy_a, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("trunc_seen", trunc[0], 0);

    // wrap-around of the frame counter
    force dut_a.pkt_cnt_q = 32'hFFFF_FFFF;
    ip_a = $urandom; trig_a = 1'b1; t = cyc;
    exp_a.push_back(build(18, 32'hFFFF_FFFF, ip_a, t + 2));
    @(negedge clk);
    trig_a = 1'b0;
    release dut_a.pkt_cnt_q;
    wait_cyc(t + 120);
    chk("wrap_pkt_cnt", pkt_cnt_a, 0);
    chk("wrap_id", {fbyte(last[0], 26), fbyte(last[0], 27)}, 16'hFFFF);
    chk("wrap_seq", {fbyte(last[0], 50), fbyte(last[0], 51), fbyte(last[0], 52), fbyte(last[0], 53)}, 32'hFFFF_FFFF);
    trig_a = 1'b1; t = cyc;
    exp_a.push_back(build(18, 0, ip_a, t + 2));
    @(negedge clk);
    trig_a = 1'b0;
    wait_cyc(t + 120);
    chk("post_wrap_pkt_cnt", pkt_cnt_a, 1);

    chk("a_frames_missing", exp_a.size(), 0);
    chk("b_frames_missing", exp_b.size(), 0);
    chk("spurious_frames", spurious, 0);
    chk("txd_nonzero_idle", idle_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
